// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if
// Purpose : groups the control/redirect inputs and the fetch outputs of the
//           fetch-address generator into one bundle.
// Signals :
//   stall          pipeline stall vector (bit 0 = PC stage)
//   branch_flag    ID-stage taken branch/jump this cycle
//   branch_target  branch target, qualified by branch_flag
//   flush          exception/eret flush, overrides stall
//   flush_pc       handler/return address, qualified by flush
//   pc             current fetch address
//   ce             fetch enable to instruction memory
//   misaligned     ce & (pc[1:0] != 0) when alignment checking is enabled
// Modports:
//   master  pipeline control side (drives redirects, observes fetch outputs)
//   slave   the generator itself
// ---------------------------------------------------------------------------
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               branch_flag;
  logic [ADDR_W-1:0]  branch_target;
  logic               flush;
  logic [ADDR_W-1:0]  flush_pc;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               misaligned;

  modport master (
    output stall, branch_flag, branch_target, flush, flush_pc,
    input  pc, ce, misaligned
  );

  modport slave (
    input  stall, branch_flag, branch_target, flush, flush_pc,
    output pc, ce, misaligned
  );
endinterface

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Purpose : fetch-address generator at the front of IF. Holds the fetch PC
//           and fetch enable, advances by INC each cycle, and handles branch
//           redirect, flush redirect, branches captured during a stall, and
//           a misalignment flag.
// Ports   :
//   clk   in  single clock, all state updates on posedge
//   rst   in  synchronous reset, active-low (0 = reset)
//   bus   pc_gen_if.slave : stall / branch_flag / branch_target / flush /
//         flush_pc in, pc / ce / misaligned out
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              STALL_W   = 6,
  parameter int              ALIGN_CHK = 1
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  // OFF : fetch disabled (ce=0)
  // RUN : fetching, no branch waiting
  // PEND: fetching, a branch arrived during a stall and is waiting
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] w_pend_target_next;
  logic              w_ce;
  logic              w_low_bits_nz;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_OFF;
      r_pc          <= RESET_VEC;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_pend_target <= w_pend_target_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state / next-pc logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_pend_target_next = r_pend_target;

    case (r_state)
      ST_OFF: begin
        // The first fetch after enabling is RESET_VEC itself, so pc is
        // held at the vector on the enabling edge.
        w_state_next = ST_RUN;
        w_pc_next    = RESET_VEC;
      end

      ST_RUN, ST_PEND: begin
        if (bus.flush) begin
          // Flush wins over stall and discards any waiting branch.
          w_pc_next    = bus.flush_pc;
          w_state_next = ST_RUN;
        end else if (bus.stall[0]) begin
          // Hold pc; remember the newest branch so it is not lost.
          if (bus.branch_flag) begin
            w_pend_target_next = bus.branch_target;
            w_state_next       = ST_PEND;
          end
        end else if (bus.branch_flag) begin
          w_pc_next    = bus.branch_target;
          w_state_next = ST_RUN;
        end else if (r_state == ST_PEND) begin
          w_pc_next    = r_pend_target;
          w_state_next = ST_RUN;
        end else begin
          // Sequential fetch; wraps modulo 2^ADDR_W.
          w_pc_next = r_pc + ADDR_W'(INC);
        end
      end

      default: begin
        w_state_next = ST_OFF;
        w_pc_next    = RESET_VEC;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Alignment check (optional)
  // ---------------------------------------------------------------------
  generate
    if (ALIGN_CHK != 0) begin : g_align
      assign w_low_bits_nz = |r_pc[1:0];
    end else begin : g_no_align
      assign w_low_bits_nz = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_ce           = (r_state != ST_OFF);
    bus.ce         = w_ce;
    bus.pc         = r_pc;
    bus.misaligned = w_ce & w_low_bits_nz;
  end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen
// Directed bench for pc_gen: reset/startup, stall hold, branch capture
// during stall, flush priority, address wrap, misalignment and reset
// dropping a pending branch. One line is printed per checked cycle.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  localparam int ADDR_W  = 32;
  localparam int STALL_W = 6;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus ();

  pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(32'h0),
    .INC      (4),
    .STALL_W  (STALL_W),
    .ALIGN_CHK(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one posedge and settle outputs before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall         = '0;
    bus.branch_flag   = 1'b0;
    bus.branch_target = '0;
    bus.flush         = 1'b0;
    bus.flush_pc      = '0;
  endtask

  // T1: reset held, then release and free-run
  task automatic test_reset();
    logic [31:0] exp_pc [3];
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("reset   cyc=%0d ce=%0b pc=%08h mis=%0b", i, bus.ce, bus.pc, bus.misaligned);
      checks++;
      if (bus.ce !== 1'b0 || bus.pc !== 32'h0 || bus.misaligned !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: ce=%0b pc=%08h mis=%0b required ce=0 pc=00000000 mis=0",
                 bus.ce, bus.pc, bus.misaligned);
      end
    end
    rst = 1'b1;
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("start   cyc=%0d ce=%0b pc=%08h", i, bus.ce, bus.pc);
      checks++;
      if (bus.ce !== 1'b1 || bus.pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL startup: ce=%0b pc=%08h required ce=1 pc=%08h", bus.ce, bus.pc, exp_pc[i]);
      end
    end
  endtask

  // T2: stall for two cycles at 0x8 (upper stall bits and an undriven
  // target must not matter)
  task automatic test_stall();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h8; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
    bus.branch_target = 'x;
    for (int i = 0; i < 4; i++) begin
      bus.stall = (i < 2) ? 6'b000001 : 6'b111110;
      tick();
      $display("stall   cyc=%0d pc=%08h", i, bus.pc);
      checks++;
      if (bus.pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL stall_hold: pc=%08h required %08h", bus.pc, exp_pc[i]);
      end
    end
    idle_inputs();
  endtask

  // T3: branch arrives in the first of three stall cycles
  task automatic test_pending_branch();
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'h10; exp_pc[1] = 32'h10; exp_pc[2] = 32'h10;
    exp_pc[3] = 32'h100; exp_pc[4] = 32'h104;
    for (int i = 0; i < 5; i++) begin
      bus.stall         = (i < 3) ? 6'b000001 : 6'b000000;
      bus.branch_flag   = (i == 0);
      bus.branch_target = (i == 0) ? 32'h100 : 32'h0;
      tick();
      $display("pend    cyc=%0d pc=%08h", i, bus.pc);
      checks++;
      if (bus.pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL pending_branch: pc=%08h required %08h", bus.pc, exp_pc[i]);
      end
    end
    idle_inputs();
  endtask

  // T4: flush beats stall and discards a waiting branch
  task automatic test_flush();
    bus.stall = 6'b000001; bus.branch_flag = 1'b1; bus.branch_target = 32'h100;
    tick();
    $display("flush   capture pc=%08h", bus.pc);
    checks++;
    if (bus.pc !== 32'h104) begin
      errors++;
      $display("FAIL flush_capture: pc=%08h required 00000104", bus.pc);
    end
    bus.branch_flag = 1'b0; bus.flush = 1'b1; bus.flush_pc = 32'h20;
    tick();
    $display("flush   redirect pc=%08h", bus.pc);
    checks++;
    if (bus.pc !== 32'h20) begin
      errors++;
      $display("FAIL flush_redirect: pc=%08h required 00000020", bus.pc);
    end
    idle_inputs();
    tick();
    $display("flush   after pc=%08h", bus.pc);
    checks++;
    if (bus.pc !== 32'h24) begin
      errors++;
      $display("FAIL flush_discard: pc=%08h required 00000024", bus.pc);
    end
  endtask

  // T5: wrap-around and misalignment
  task automatic test_wrap_misalign();
    logic [31:0] exp_pc [3];
    bus.branch_flag = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
    exp_pc[0] = 32'hFFFF_FFFC; exp_pc[1] = 32'h0; exp_pc[2] = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.branch_flag = 1'b0;
      $display("wrap    cyc=%0d pc=%08h mis=%0b", i, bus.pc, bus.misaligned);
      checks++;
      if (bus.pc !== exp_pc[i] || bus.misaligned !== 1'b0) begin
        errors++;
        $display("FAIL wrap: pc=%08h mis=%0b required pc=%08h mis=0",
                 bus.pc, bus.misaligned, exp_pc[i]);
      end
    end
    bus.branch_flag = 1'b1; bus.branch_target = 32'h102;
    tick();
    $display("misal   pc=%08h mis=%0b", bus.pc, bus.misaligned);
    checks++;
    if (bus.pc !== 32'h102 || bus.misaligned !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_set: pc=%08h mis=%0b required pc=00000102 mis=1",
               bus.pc, bus.misaligned);
    end
    bus.branch_target = 32'h180;
    tick();
    $display("misal   pc=%08h mis=%0b", bus.pc, bus.misaligned);
    checks++;
    if (bus.pc !== 32'h180 || bus.misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_clear: pc=%08h mis=%0b required pc=00000180 mis=0",
               bus.pc, bus.misaligned);
    end
    idle_inputs();
  endtask

  // T6: reset while a branch is pending drops it
  task automatic test_reset_drops_pending();
    logic [31:0] exp_pc [2];
    bus.stall = 6'b000001; bus.branch_flag = 1'b1; bus.branch_target = 32'h200;
    tick();
    $display("rstpend capture pc=%08h", bus.pc);
    checks++;
    if (bus.pc !== 32'h180) begin
      errors++;
      $display("FAIL rstpend_capture: pc=%08h required 00000180", bus.pc);
    end
    idle_inputs();
    rst = 1'b0;
    tick();
    $display("rstpend reset ce=%0b pc=%08h", bus.ce, bus.pc);
    checks++;
    if (bus.ce !== 1'b0 || bus.pc !== 32'h0) begin
      errors++;
      $display("FAIL rstpend_reset: ce=%0b pc=%08h required ce=0 pc=00000000", bus.ce, bus.pc);
    end
    rst = 1'b1;
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4;
    for (int i = 0; i < 2; i++) begin
      tick();
      $display("rstpend cyc=%0d ce=%0b pc=%08h", i, bus.ce, bus.pc);
      checks++;
      if (bus.ce !== 1'b1 || bus.pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL rstpend_release: ce=%0b pc=%08h required ce=1 pc=%08h",
                 bus.ce, bus.pc, exp_pc[i]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_stall();
    test_pending_branch();
    test_flush();
    test_wrap_misalign();
    test_reset_drops_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
